register_bank_ex: RTL
=====================

REGISTER_BANK_EX -- requirements
Module: register_bank_ex

Interface
REQ-001 Parameter NrOfBits, default 8: data width of each word, legal range 1..32.
REQ-002 Parameter NrOfWords, default 4: number of words, legal range 2..16.
REQ-003 Parameter AddrBits, default 2: address width; SHALL satisfy 2^AddrBits >= NrOfWords.
REQ-004 Parameter ActiveLevel, default 1: 1 = all state updates on the rising Clock edge, 0 = on the falling edge.
REQ-005 Clock  in  1  single clock; the only clock.
REQ-006 Reset  in  1  asynchronous, active-low reset; 0 clears all state.
REQ-007 ClockEnable  in  1  update qualifier, ANDed with Tick.
REQ-008 Tick  in  1  update qualifier, ANDed with ClockEnable.
REQ-009 Mode  in  2  operation: 00 load, 01 shift, 10 rotate, 11 preset.
REQ-010 WrAddr  in  AddrBits  target word for load and preset.
REQ-011 D  in  NrOfBits  write data for load; shift-in data for shift.
REQ-012 Clear  in  1  synchronous clear of ValidMask only; word contents are kept.
REQ-013 RdAddr  in  AddrBits  read select.
REQ-014 cs  in  1  1 = Q high-impedance; 0 = Q driven.
REQ-015 Q  out  NrOfBits  word[RdAddr]; all-z when cs=1.
REQ-016 ValidMask  out  NrOfWords  bit i = 1 when word i holds written data.
REQ-017 Full  out  1  1 when all ValidMask bits are 1.

Function
REQ-018 The block SHALL update state only on the active edge selected by ActiveLevel, and only when ClockEnable=1 and Tick=1. This condition is called "upd".
REQ-019 Load (00) with upd: word[WrAddr] <= D and ValidMask[WrAddr] <= 1. The block SHALL ignore a write when WrAddr >= NrOfWords, leaving all state unchanged.
REQ-020 Shift (01) with upd, in one edge:
  - word[i] <= word[i-1] for i = 1..NrOfWords-1, and word[0] <= D.
  - ValidMask SHALL shift the same way, with a 1 entering at bit 0.
  - The top word and its valid bit SHALL be discarded.
REQ-021 Rotate (10) with upd: word[i] <= word[i-1] and word[0] <= word[NrOfWords-1]. ValidMask SHALL rotate identically. D SHALL be ignored.
REQ-022 Preset (11) with upd: word[WrAddr] <= all ones and ValidMask[WrAddr] <= 1. The out-of-range rule of REQ-019 SHALL apply.
REQ-023 Clear=1 on an active edge SHALL force ValidMask to 0 regardless of upd, and SHALL take priority over any ValidMask update in the same edge. The word update of that edge SHALL still occur.
REQ-024 Q SHALL be combinational from the stored words: a write becomes visible on Q after the active edge, with no same-edge write-through. When RdAddr >= NrOfWords, Q SHALL be 0 (with cs=0).
REQ-025 Full SHALL be combinational: Full = AND of ValidMask.
REQ-026 Without upd, words SHALL hold; Mode, WrAddr and D SHALL have no effect.

Reset
REQ-027 Reset=0 SHALL immediately, without waiting for a clock edge, clear every word and ValidMask to 0. Consequently Full=0, and Q=0 when cs=0.
REQ-028 Reset SHALL override all other inputs, including a preset or edge in progress. The first update after Reset returns to 1 SHALL occur on the next qualifying active edge.
REQ-029 The cs/Q tri-state behaviour SHALL be unaffected by Reset.

Verification
REQ-030 NrOfBits=8, NrOfWords=4: load 0x11, 0x22, 0x33, 0x44 to addresses 0..3 with upd -> RdAddr 0..3 reads 0x11..0x44, ValidMask=1111, Full=1.
REQ-031 Mode=01, D=0xAA, one upd edge after REQ-030 -> words = {0xAA, 0x11, 0x22, 0x33}, 0x44 discarded, ValidMask=1111.
REQ-032 Mode=10, one upd edge from {1,2,3,4} -> {4,1,2,3}. Then Mode=11, WrAddr=2 -> word2=0xFF.
REQ-033 Tick=0 with ClockEnable=1 on a load edge -> no change. WrAddr=5 with NrOfWords=4 -> no change. Clear=1 with a load to address 1 -> word1 updated, ValidMask=0000, Full=0.
REQ-034 Reset driven low between edges during a shift sequence -> all words and ValidMask are 0 before the next edge. cs=1 -> Q=zzzzzzzz at all times.
REQ-035 Repeat REQ-030 with ActiveLevel=0 -> all updates occur on falling edges only.

Source files
------------

// File: rtl/register_bank_ex.sv
// Small register bank with load, shift, rotate and preset modes, plus a valid mask.
// Q and Full are combinational from the stored state. Q is tri-stated by cs.
module register_bank_ex #(
    parameter int NrOfBits    = 8,
    parameter int NrOfWords   = 4,
    parameter int AddrBits    = 2,
    parameter int ActiveLevel = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 ClockEnable,
    input  logic                 Tick,
    input  logic [1:0]           Mode,
    input  logic [AddrBits-1:0]  WrAddr,
    input  logic [NrOfBits-1:0]  D,
    input  logic                 Clear,
    input  logic [AddrBits-1:0]  RdAddr,
    input  logic                 cs,
    output logic [NrOfBits-1:0]  Q,
    output logic [NrOfWords-1:0] ValidMask,
    output logic                 Full
);

    typedef enum logic [1:0] {
        MODE_LOAD   = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_PRESET = 2'b11
    } mode_e;

    logic [NrOfBits-1:0]  word_reg  [NrOfWords];
    logic [NrOfBits-1:0]  word_next [NrOfWords];
    logic [NrOfWords-1:0] valid_reg;
    logic [NrOfWords-1:0] valid_next;
    logic [NrOfBits-1:0]  rd_data;
    logic                 upd;

    assign upd = ClockEnable & Tick;

    // Out-of-range write addresses match no word, so they leave all state untouched.
    always_comb begin
        for (int i = 0; i < NrOfWords; i++) begin
            word_next[i] = word_reg[i];
        end
        valid_next = valid_reg;
        if (upd) begin
            case (mode_e'(Mode))
                MODE_LOAD: begin
                    for (int i = 0; i < NrOfWords; i++) begin
                        if (WrAddr == AddrBits'(i)) begin
                            word_next[i]  = D;
                            valid_next[i] = 1'b1;
                        end
                    end
                end
                MODE_SHIFT: begin
                    word_next[0] = D;
                    for (int i = 1; i < NrOfWords; i++) begin
                        word_next[i] = word_reg[i-1];
                    end
                    valid_next = {valid_reg[NrOfWords-2:0], 1'b1};
                end
                MODE_ROTATE: begin
                    word_next[0] = word_reg[NrOfWords-1];
                    for (int i = 1; i < NrOfWords; i++) begin
                        word_next[i] = word_reg[i-1];
                    end
                    valid_next = {valid_reg[NrOfWords-2:0], valid_reg[NrOfWords-1]};
                end
                MODE_PRESET: begin
                    for (int i = 0; i < NrOfWords; i++) begin
                        if (WrAddr == AddrBits'(i)) begin
                            word_next[i]  = '1;
                            valid_next[i] = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
        // Clear wins over any mask update but leaves the word update alone.
        if (Clear) begin
            valid_next = '0;
        end
    end

    generate
        if (ActiveLevel != 0) begin : g_rise
            always_ff @(posedge Clock or negedge Reset) begin
                if (!Reset) begin
                    for (int i = 0; i < NrOfWords; i++) begin
                        word_reg[i] <= '0;
                    end
                    valid_reg <= '0;
                end else begin
                    for (int i = 0; i < NrOfWords; i++) begin
                        word_reg[i] <= word_next[i];
                    end
                    valid_reg <= valid_next;
                end
            end
        end else begin : g_fall
            always_ff @(negedge Clock or negedge Reset) begin
                if (!Reset) begin
                    for (int i = 0; i < NrOfWords; i++) begin
                        word_reg[i] <= '0;
                    end
                    valid_reg <= '0;
                end else begin
                    for (int i = 0; i < NrOfWords; i++) begin
                        word_reg[i] <= word_next[i];
                    end
                    valid_reg <= valid_next;
                end
            end
        end
    endgenerate

    // Read addresses beyond the last word select nothing and read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NrOfWords; i++) begin
            if (RdAddr == AddrBits'(i)) begin
                rd_data = word_reg[i];
            end
        end
    end

    assign Q         = cs ? {NrOfBits{1'bz}} : rd_data;
    assign ValidMask = valid_reg;
    assign Full      = &valid_reg;

endmodule
